// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multi-cycle control FSM for the 8-bit datapath, with a memory
//            ready/timeout handshake and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Run,
    input  logic [7:0]       Instr,
    input  logic             MemReady,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic [3:0]       State,
    output logic             Busy,
    output logic             Err,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_M   = 4'd7,
        S_MEM_WR = 4'd8,
        S_JUMP   = 4'd9,
        S_ERROR  = 4'd10
    } state_t;

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    state_t           r_state;
    logic [7:0]       r_wait;
    logic             r_err;
    logic [CNT_W-1:0] r_count;

    logic w_mem_state;
    logic w_timeout;
    logic w_retire;
    logic w_unused_instr;

    assign w_unused_instr = &{1'b0, Instr[5:0]};

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR);
    assign w_timeout   = (r_wait == c_timeout) && !MemReady;
    assign w_retire    = (r_state == S_WB_R) || (r_state == S_WB_M) ||
                         (r_state == S_JUMP) ||
                         ((r_state == S_MEM_WR) && MemReady);

    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_retire)
                r_count <= r_count + 1'b1;

            // Wait counter only runs while a memory request is outstanding;
            // holding it at zero elsewhere gives a clean start on every entry.
            if (w_mem_state && !MemReady && !w_timeout)
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= '0;

            if (w_mem_state && w_timeout)
                r_err <= 1'b1;

            case (r_state)
                S_IDLE:   if (Run) r_state <= S_FETCH;
                S_FETCH: begin
                    if (MemReady)       r_state <= S_DECODE;
                    else if (w_timeout) r_state <= S_ERROR;
                end
                S_DECODE: begin
                    case (Instr[7:6])
                        2'b00:   r_state <= S_EXEC_R;
                        2'b11:   r_state <= S_JUMP;
                        default: r_state <= S_ADDR;
                    endcase
                end
                S_EXEC_R: r_state <= S_WB_R;
                S_ADDR:   r_state <= (Instr[7:6] == 2'b10) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (MemReady)       r_state <= S_WB_M;
                    else if (w_timeout) r_state <= S_ERROR;
                end
                S_MEM_WR: begin
                    if (MemReady)       r_state <= Run ? S_FETCH : S_IDLE;
                    else if (w_timeout) r_state <= S_ERROR;
                end
                S_WB_R, S_WB_M, S_JUMP: r_state <= Run ? S_FETCH : S_IDLE;
                S_ERROR:  r_state <= S_ERROR;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDR:   ALUSrc = 1'b1;
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                ALUSrc  = 1'b1;
            end
            S_WB_M: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                ALUSrc   = 1'b1;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 1'b1;
            end
            default: ;
        endcase
    end

    assign State      = r_state;
    assign Busy       = (r_state != S_IDLE) && (r_state != S_ERROR);
    assign Err        = r_err;
    assign InstrCount = r_count;

endmodule
`default_nettype wire
